// File: rtl/ltc_pkg.sv
// Shared LTC constants, frame type, FSM encoding and the polarity-correction helper.
package ltc_pkg;

  localparam int          LTC_FRAME_BITS = 80;
  localparam logic [15:0] LTC_SYNC_WORD  = 16'hBFFC;
  localparam int          LTC_PCB_BIT_25 = 59;
  localparam int          LTC_PCB_BIT_30 = 27;

  typedef logic [LTC_FRAME_BITS-1:0] ltc_frame_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ltc_state_t;

  // Force the chosen bit so the whole frame carries an even number of ones.
  function automatic ltc_frame_t ltc_fix_polarity(input ltc_frame_t f, input logic [6:0] pcb);
    ltc_frame_t r;
    r      = f;
    r[pcb] = 1'b0;
    r[pcb] = ^r;
    return r;
  endfunction

endpackage

// File: rtl/ltc_halfbit_tick.sv
// Half-bit-cell divider: tick is high in the last cycle of every DIV-cycle period.
// A synchronous clear restarts the period so the next tick lands exactly DIV cycles later.
module ltc_halfbit_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/ltc_bmc_tx.sv
// Double-buffered biphase-mark LTC transmitter, 80-bit frames sent LSB first, D = CLK_FREQ/(LTC_FPS*160) >= 2.
// Define LTC_POLARITY_CORR_EN to rewrite the polarity correction bit at load time for even frame parity.
module ltc_bmc_tx
  import ltc_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int LTC_FPS  = 25
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [LTC_FRAME_BITS-1:0] frame_data,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic                      ltc_out,
  output logic                      frame_start,
  output logic                      underrun,
  output logic                      busy
);

  localparam int         D       = CLK_FREQ / (LTC_FPS * 160);
  localparam logic [6:0] LAST    = 7'(LTC_FRAME_BITS - 1);
  localparam logic [6:0] PCB_BIT = (LTC_FPS == 25) ? 7'(LTC_PCB_BIT_25) : 7'(LTC_PCB_BIT_30);

  ltc_state_t state;
  ltc_frame_t hold;
  ltc_frame_t shifter;
  ltc_frame_t load_data;
  logic       hold_full;
  logic       hold_full_nxt;
  logic [6:0] bit_idx;
  logic       second_half;
  logic       tick;
  logic       accept;
  logic       frame_end;
  logic       load;

  ltc_halfbit_tick #(
    .DIV (D)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (load),
    .tick    (tick)
  );

  assign accept    = frame_valid && frame_ready;
  assign frame_end = (state == ST_SHIFT) && tick && second_half && (bit_idx == LAST);
  // Only a frame already in the holding register at frame end continues seamlessly;
  // one accepted on that same cycle is loaded from IDLE one cycle later.
  assign load      = hold_full && ((state == ST_IDLE) || frame_end);

  always_comb begin
    hold_full_nxt = hold_full;
    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (load) begin
      hold_full_nxt = 1'b0;
    end
  end

`ifdef LTC_POLARITY_CORR_EN
  assign load_data = ltc_fix_polarity(hold, PCB_BIT);
`else
  assign load_data = hold;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hold        <= '0;
      hold_full   <= 1'b0;
      shifter     <= '0;
      bit_idx     <= '0;
      second_half <= 1'b0;
      ltc_out     <= 1'b0;
      frame_ready <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= frame_end && !hold_full;
      hold_full   <= hold_full_nxt;
      frame_ready <= !hold_full_nxt;

      if (accept) begin
        hold <= frame_data;
      end else if (load) begin
        hold <= '0;
      end

      if (load) begin
        state       <= ST_SHIFT;
        busy        <= 1'b1;
        shifter     <= load_data;
        bit_idx     <= '0;
        second_half <= 1'b0;
        ltc_out     <= ~ltc_out;
      end else if ((state == ST_SHIFT) && tick) begin
        if (!second_half) begin
          second_half <= 1'b1;
          if (shifter[0]) begin
            ltc_out <= ~ltc_out;
          end
        end else if (bit_idx == LAST) begin
          // Starved: park the line at its current level until the next load.
          state       <= ST_IDLE;
          busy        <= 1'b0;
          second_half <= 1'b0;
        end else begin
          second_half <= 1'b0;
          bit_idx     <= bit_idx + 7'd1;
          shifter     <= {1'b0, shifter[LTC_FRAME_BITS-1:1]};
          ltc_out     <= ~ltc_out;
        end
      end
    end
  end

endmodule
